// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - E-stage issue/stall controller for the HI/LO multiply/divide unit
// Drives start/ctrl/A/B, tracks the in-flight op, stalls dependents, keeps watchdog and stall counters.
module md_issue_ctrl #(
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic             req_read,
  input  logic [31:0]      req_rs,
  input  logic [31:0]      req_rt,
  input  logic             flush,
  output logic             stall,
  output logic             md_start,
  output logic [2:0]       md_ctrl,
  output logic [31:0]      md_A,
  output logic [31:0]      md_B,
  input  logic             md_busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [2:0] MT_SET_HI = 3'd5;
  localparam logic [2:0] MT_SET_LO = 3'd6;
  localparam int         WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE, INFLIGHT} state_t;

  state_t          state, state_d;
  logic [WD_W-1:0] wd_cnt, wd_cnt_d;
  logic            err_set;
  logic            is_set, is_arith, free, issue;

  assign md_ctrl = req_op;
  assign md_A    = req_rs;
  assign md_B    = req_rt;

  // Anything that is not a HI/LO write (including unknown codes) occupies the unit.
  assign is_set   = (req_op == MT_SET_HI) || (req_op == MT_SET_LO);
  assign is_arith = !is_set;

  assign free     = (state == IDLE) || (state == INFLIGHT && !md_busy);
  assign issue    = req_valid && !req_read && !flush && free;
  assign md_start = issue;
  assign stall    = req_valid && !flush && !free;

  always_comb begin
    state_d  = state;
    wd_cnt_d = wd_cnt;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (issue && is_arith) begin
          state_d  = INFLIGHT;
          wd_cnt_d = '0;
        end
      end
      INFLIGHT: begin
        if (md_busy) begin
          if (wd_cnt == WD_LAST) begin
            state_d = IDLE;
            err_set = 1'b1;
          end else begin
            wd_cnt_d = wd_cnt + 1'b1;
          end
        end else if (issue && is_arith) begin
          // Completion cycle doubles as the issue cycle of the next op.
          state_d  = INFLIGHT;
          wd_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      wd_cnt       <= '0;
      err_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state  <= state_d;
      wd_cnt <= wd_cnt_d;
      if (err_set) err_timeout <= 1'b1;
      if (stall && (stall_cycles != {CNT_W{1'b1}})) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - directed bench for md_issue_ctrl with a behavioural HI/LO unit
// Second instance (TIMEOUT=4, CNT_W=3) exercises the watchdog and counter saturation.
module tb_md_issue_ctrl;

  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] MULTU = 3'd2;
  localparam logic [2:0] DIV   = 3'd3;
  localparam logic [2:0] DIVU  = 3'd4;
  localparam logic [2:0] SETHI = 3'd5;
  localparam logic [2:0] SETLO = 3'd6;

  logic clk = 0;
  logic reset_n;
  logic req_valid, req_read, flush;
  logic [2:0] req_op;
  logic [31:0] req_rs, req_rt;
  logic stall, md_start, md_busy, err_timeout;
  logic [2:0] md_ctrl;
  logic [31:0] md_A, md_B, stall_cycles;

  logic w_valid, w_busy;
  logic [2:0] w_op;
  logic w_stall, w_start, w_err;
  logic [2:0] w_ctrl, w_sc;
  logic [31:0] w_A, w_B;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  md_issue_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
    .req_read(req_read), .req_rs(req_rs), .req_rt(req_rt), .flush(flush),
    .stall(stall), .md_start(md_start), .md_ctrl(md_ctrl), .md_A(md_A), .md_B(md_B),
    .md_busy(md_busy), .err_timeout(err_timeout), .stall_cycles(stall_cycles)
  );

  md_issue_ctrl #(.TIMEOUT(4), .CNT_W(3)) u_wd (
    .clk(clk), .reset_n(reset_n), .req_valid(w_valid), .req_op(w_op),
    .req_read(1'b0), .req_rs(32'd1), .req_rt(32'd2), .flush(1'b0),
    .stall(w_stall), .md_start(w_start), .md_ctrl(w_ctrl), .md_A(w_A), .md_B(w_B),
    .md_busy(w_busy), .err_timeout(w_err), .stall_cycles(w_sc)
  );

  // Behavioural MD unit: 5-cycle mult, 10-cycle div, HI/LO committed as busy drops.
  int m_cnt;
  logic [31:0] hi, lo, p_hi, p_lo;
  logic [63:0] prod;
  assign md_busy = (m_cnt != 0);

  always @(posedge clk) begin
    if (!reset_n) begin
      m_cnt <= 0;
    end else begin
      if (m_cnt == 1) begin
        hi <= p_hi;
        lo <= p_lo;
      end
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      if (md_start) begin
        case (md_ctrl)
          MULT: begin
            prod = {{32{md_A[31]}}, md_A} * {{32{md_B[31]}}, md_B};
            p_hi <= prod[63:32]; p_lo <= prod[31:0]; m_cnt <= 5;
          end
          MULTU: begin
            prod = {32'd0, md_A} * {32'd0, md_B};
            p_hi <= prod[63:32]; p_lo <= prod[31:0]; m_cnt <= 5;
          end
          DIV: begin
            if (md_B != 0) begin
              p_lo <= $signed(md_A) / $signed(md_B);
              p_hi <= $signed(md_A) % $signed(md_B);
            end
            m_cnt <= 10;
          end
          DIVU: begin
            if (md_B != 0) begin
              p_lo <= md_A / md_B;
              p_hi <= md_A % md_B;
            end
            m_cnt <= 10;
          end
          SETHI: hi <= md_A;
          SETLO: lo <= md_A;
          default: m_cnt <= 5;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic rd,
                       input logic [31:0] a, input logic [31:0] b, input logic fl);
    req_valid = v; req_op = op; req_read = rd; req_rs = a; req_rt = b; flush = fl;
    #1;
  endtask

  initial begin
    reset_n = 0; w_valid = 0; w_busy = 0; w_op = MULT;
    drive(0, 3'd0, 0, 0, 0, 0);
    repeat (3) tick();
    reset_n = 1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_sc", stall_cycles, 0);
    chk("rst_start", md_start, 0);

    // 1: mult 7 * -3, then mflo waits 5 cycles
    drive(1, MULT, 0, 32'd7, 32'hFFFF_FFFD, 0);
    chk("t1_start", md_start, 1);
    chk("t1_stall", stall, 0);
    chk("t1_ctrl", md_ctrl, MULT);
    chk("t1_A", md_A, 32'd7);
    chk("t1_B", md_B, 32'hFFFF_FFFD);
    tick();
    drive(1, SETLO, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t1_mflo_stall", stall, 1);
      chk("t1_mflo_nostart", md_start, 0);
      tick();
    end
    chk("t1_mflo_go", stall, 0);
    chk("t1_lo", lo, 32'hFFFF_FFEB);
    chk("t1_sc", stall_cycles, 5);
    tick();

    // 2: divu 100/7 then div -100/7 issued in the completion cycle
    drive(1, DIVU, 0, 32'd100, 32'd7, 0);
    chk("t2_start1", md_start, 1);
    tick();
    drive(1, DIV, 0, 32'hFFFF_FF9C, 32'd7, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t2_wait", stall, 1);
      tick();
    end
    chk("t2_start2", md_start, 1);
    chk("t2_nostall", stall, 0);
    chk("t2_hi", hi, 32'd2);
    chk("t2_lo", lo, 32'd14);
    tick();
    drive(0, 3'd0, 0, 0, 0, 0);
    chk("t2_hi_hold", hi, 32'd2);
    chk("t2_busy2", md_busy, 1);
    repeat (10) tick();
    chk("t2_lo2", lo, 32'hFFFF_FFF2);
    chk("t2_hi2", hi, 32'hFFFF_FFFE);
    chk("t2_sc", stall_cycles, 15);

    // 3: mthi stays IDLE, mfhi right after is not stalled
    drive(1, SETHI, 0, 32'hDEAD_BEEF, 0, 0);
    chk("t3_start", md_start, 1);
    chk("t3_stall", stall, 0);
    tick();
    drive(1, SETHI, 1, 0, 0, 0);
    chk("t3_mfhi_stall", stall, 0);
    chk("t3_mfhi_start", md_start, 0);
    chk("t3_hi", hi, 32'hDEAD_BEEF);
    tick();

    // 4: flushed request while busy neither stalls nor issues
    drive(1, MULT, 0, 32'd6, 32'd5, 0);
    chk("t4_start", md_start, 1);
    tick();
    drive(1, MULT, 0, 32'd9, 32'd9, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_fl_stall", stall, 0);
      chk("t4_fl_start", md_start, 0);
      tick();
    end
    drive(0, 3'd0, 0, 0, 0, 0);
    chk("t4_lo", lo, 32'd30);
    chk("t4_sc", stall_cycles, 15);

    // 5: watchdog on TIMEOUT=4 instance, counter saturates at 7
    w_busy = 1; w_valid = 1; w_op = MULT;
    #1;
    chk("t5_start", w_start, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t5_stall", w_stall, 1);
      chk("t5_err_pre", w_err, 0);
      tick();
    end
    chk("t5_err", w_err, 1);
    chk("t5_free", w_stall, 0);
    chk("t5_reissue", w_start, 1);
    chk("t5_sc", w_sc, 4);
    tick();
    repeat (4) tick();
    chk("t5_sat", w_sc, 7);
    chk("t5_sticky", w_err, 1);
    w_valid = 0;

    // 6: reset in the middle of a divide
    drive(1, DIV, 0, 32'd50, 32'd3, 0);
    chk("t6_start", md_start, 1);
    tick();
    drive(1, SETHI, 1, 0, 0, 0);
    repeat (3) tick();
    chk("t6_busy_stall", stall, 1);
    reset_n = 0;
    tick();
    reset_n = 1;
    #1;
    chk("t6_stall", stall, 0);
    chk("t6_err", w_err, 0);
    chk("t6_sc", stall_cycles, 0);
    chk("t6_wsc", w_sc, 0);
    drive(1, MULT, 0, 32'd2, 32'd3, 0);
    chk("t6_idle_issue", md_start, 1);
    tick();
    drive(0, 3'd0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
